cdb_arbiter: RTL and testbench

- Shares one common data bus (CDB) between two result producers: the RS/ALU result port and the LSB load-result port.
- Each source has a small per-source result queue. Round-robin arbitration drives a single registered broadcast that the dispatcher, RS, LSB and ROB snoop for operand wakeup.
- Replaces independent rs/ls CDBs with one arbitrated bus plus backpressure. Clears on ROB rollback.

---
 rtl/cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered common data bus between the ALU result port
// and the LSB load-result port. Each source has a DEPTH-entry FIFO; contention is
// resolved round-robin, and the pointer moves to the loser after a contended grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready; low freezes all state
//   rollback_flag            ROB flush: empties queues, kills next broadcast
//   valid/rob_id/result_from_alu, ready_to_alu   ALU result handshake
//   valid/rob_id/result_from_lsb, ready_to_lsb   LSB result handshake
//   cdb_valid/rob_id/result/src                  registered broadcast (src 0=ALU, 1=LSB)
module cdb_arbiter #(
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback_flag,
  input  logic                    valid_from_alu,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_alu,
  input  logic [DATA_WIDTH-1:0]   result_from_alu,
  output logic                    ready_to_alu,
  input  logic                    valid_from_lsb,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_lsb,
  input  logic [DATA_WIDTH-1:0]   result_from_lsb,
  output logic                    ready_to_lsb,
  output logic                    cdb_valid,
  output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
  output logic [DATA_WIDTH-1:0]   cdb_result,
  output logic                    cdb_src
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Index 0 = ALU, index 1 = LSB throughout.
  logic [1:0]              in_valid;
  logic [ROB_ID_WIDTH-1:0] in_tag  [2];
  logic [DATA_WIDTH-1:0]   in_data [2];

  assign in_valid   = {valid_from_lsb, valid_from_alu};
  assign in_tag[0]  = rob_id_from_alu;
  assign in_tag[1]  = rob_id_from_lsb;
  assign in_data[0] = result_from_alu;
  assign in_data[1] = result_from_lsb;

  logic [ROB_ID_WIDTH-1:0] tag_mem_q  [2][DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem_q [2][DEPTH];
  logic [PtrW-1:0]         head_q     [2];
  logic [PtrW-1:0]         tail_q     [2];
  logic [CntW-1:0]         cnt_q      [2];
  logic                    prio_q, prio_d;

  logic [1:0]              ready, has_head, accept, cand, gnt, push, pop;
  logic [ROB_ID_WIDTH-1:0] cand_tag  [2];
  logic [DATA_WIDTH-1:0]   cand_data [2];
  logic [ROB_ID_WIDTH-1:0] win_tag;
  logic [DATA_WIDTH-1:0]   win_data;

  logic                    cdb_valid_q;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q;
  logic [DATA_WIDTH-1:0]   cdb_result_q;
  logic                    cdb_src_q;

  // Ready depends only on registered count and rdy, never on the valid inputs.
  always_comb begin
    ready     = '0;
    has_head  = '0;
    accept    = '0;
    cand      = '0;
    cand_tag  = '{default: '0};
    cand_data = '{default: '0};
    for (int s = 0; s < 2; s++) begin
      ready[s]     = rdy && (cnt_q[s] < CntW'(DEPTH));
      has_head[s]  = (cnt_q[s] != '0);
      accept[s]    = in_valid[s] && ready[s] && !rollback_flag;
      cand[s]      = has_head[s] || accept[s];
      // A queued head always goes first so inputs never overtake older entries.
      cand_tag[s]  = has_head[s] ? tag_mem_q[s][head_q[s]]  : in_tag[s];
      cand_data[s] = has_head[s] ? data_mem_q[s][head_q[s]] : in_data[s];
    end
  end

  assign ready_to_alu = ready[0];
  assign ready_to_lsb = ready[1];

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (rdy && !rollback_flag) begin
      if (&cand) begin
        gnt[prio_q] = 1'b1;
        prio_d      = ~prio_q;  // loser gets priority next time
      end else begin
        gnt = cand;
      end
    end
  end

  // An input that wins with an empty queue bypasses storage entirely.
  assign pop      = gnt & has_head;
  assign push     = accept & ~(gnt & ~has_head);
  assign win_tag  = gnt[1] ? cand_tag[1]  : cand_tag[0];
  assign win_data = gnt[1] ? cand_data[1] : cand_data[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      prio_q       <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_result_q <= '0;
      cdb_src_q    <= 1'b0;
    end else if (rdy) begin
      if (rollback_flag) begin
        for (int s = 0; s < 2; s++) begin
          head_q[s] <= '0;
          tail_q[s] <= '0;
          cnt_q[s]  <= '0;
        end
        cdb_valid_q <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (pop[s])  head_q[s] <= head_q[s] + PtrW'(1);
          if (push[s]) tail_q[s] <= tail_q[s] + PtrW'(1);
          if (push[s] && !pop[s])      cnt_q[s] <= cnt_q[s] + CntW'(1);
          else if (pop[s] && !push[s]) cnt_q[s] <= cnt_q[s] - CntW'(1);
        end
        prio_q      <= prio_d;
        cdb_valid_q <= |gnt;
        if (|gnt) begin
          cdb_rob_id_q <= win_tag;
          cdb_result_q <= win_data;
          cdb_src_q    <= gnt[1];
        end
      end
    end
  end

  // Storage has no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        tag_mem_q[s][tail_q[s]]  <= in_tag[s];
        data_mem_q[s][tail_q[s]] <= in_data[s];
      end
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_result = cdb_result_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter. A queue-based reference model
// tracks per-source FIFOs and the round-robin pointer; a negedge process checks
// every DUT output against it each cycle, and directed steps add literal checks.
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int D  = 2;

  logic          clk, rst, rdy, rollback_flag;
  logic          valid_from_alu, valid_from_lsb;
  logic [RW-1:0] rob_id_from_alu, rob_id_from_lsb;
  logic [DW-1:0] result_from_alu, result_from_lsb;
  logic          ready_to_alu, ready_to_lsb;
  logic          cdb_valid, cdb_src;
  logic [RW-1:0] cdb_rob_id;
  logic [DW-1:0] cdb_result;

  cdb_arbiter #(.ROB_ID_WIDTH(RW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .rollback_flag   (rollback_flag),
    .valid_from_alu  (valid_from_alu),
    .rob_id_from_alu (rob_id_from_alu),
    .result_from_alu (result_from_alu),
    .ready_to_alu    (ready_to_alu),
    .valid_from_lsb  (valid_from_lsb),
    .rob_id_from_lsb (rob_id_from_lsb),
    .result_from_lsb (result_from_lsb),
    .ready_to_lsb    (ready_to_lsb),
    .cdb_valid       (cdb_valid),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_result      (cdb_result),
    .cdb_src         (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq_a[$];
  ent_t          mq_l[$];
  bit            m_ptr;     // 0 = ALU has priority
  bit            m_valid;
  logic [RW-1:0] m_tag;
  logic [DW-1:0] m_data;
  bit            m_src;

  always @(posedge clk) begin : model
    bit   ok_a, ok_l, ca, cl, win;
    ent_t e;
    if (rst) begin
      mq_a.delete();
      mq_l.delete();
      m_ptr = 1'b0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 1'b0;
    end else if (rdy) begin
      if (rollback_flag) begin
        mq_a.delete();
        mq_l.delete();
        m_valid = 1'b0;
      end else begin
        ok_a = (mq_a.size() < D);
        ok_l = (mq_l.size() < D);
        if (valid_from_alu) begin
          check("proto_alu_ready", ok_a, 1'b1);
          check("proto_alu_tag_nonzero", rob_id_from_alu != 0, 1'b1);
        end
        if (valid_from_lsb) begin
          check("proto_lsb_ready", ok_l, 1'b1);
          check("proto_lsb_tag_nonzero", rob_id_from_lsb != 0, 1'b1);
        end
        // Appending the input then serving the front keeps arrival order.
        if (valid_from_alu && ok_a) mq_a.push_back('{rob_id_from_alu, result_from_alu});
        if (valid_from_lsb && ok_l) mq_l.push_back('{rob_id_from_lsb, result_from_lsb});
        ca = mq_a.size() > 0;
        cl = mq_l.size() > 0;
        if (ca && cl) begin
          win = m_ptr;
          m_ptr = ~m_ptr;
        end else begin
          win = cl;
        end
        if (ca || cl) begin
          e = win ? mq_l.pop_front() : mq_a.pop_front();
          m_valid = 1'b1; m_tag = e.tag; m_data = e.data; m_src = win;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    check("ready_to_alu", ready_to_alu, rdy && mq_a.size() < D);
    check("ready_to_lsb", ready_to_lsb, rdy && mq_l.size() < D);
    check("cdb_valid", cdb_valid, m_valid);
    if (m_valid) begin
      check("cdb_rob_id", cdb_rob_id, m_tag);
      check("cdb_result", cdb_result, m_data);
      check("cdb_src", cdb_src, m_src);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set(input bit va, input int ta, input int da,
                     input bit vl, input int tl, input int dl,
                     input bit rb = 0, input bit r = 1, input bit rs = 0);
    #1;
    rst = rs; rdy = r; rollback_flag = rb;
    valid_from_alu = va; rob_id_from_alu = RW'(ta); result_from_alu = DW'(da);
    valid_from_lsb = vl; rob_id_from_lsb = RW'(tl); result_from_lsb = DW'(dl);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nxt();
  endtask

  int tag_a, tag_l;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback_flag = 1'b0;
    valid_from_alu = 1'b0; rob_id_from_alu = '0; result_from_alu = '0;
    valid_from_lsb = 1'b0; rob_id_from_lsb = '0; result_from_lsb = '0;
    nxt();
    check("reset_cdb_valid", cdb_valid, 1'b0);
    check("reset_cdb_rob_id", cdb_rob_id, 0);
    check("reset_cdb_result", cdb_result, 0);
    check("reset_cdb_src", cdb_src, 1'b0);
    check("reset_ready_alu", ready_to_alu, 1'b1);
    check("reset_ready_lsb", ready_to_lsb, 1'b1);

    // Single ALU result.
    set(1, 3, 'h11, 0, 0, 0);
    nxt();
    check("single_valid", cdb_valid, 1'b1);
    check("single_tag", cdb_rob_id, 3);
    check("single_result", cdb_result, 'h11);
    check("single_src", cdb_src, 1'b0);
    set(0, 0, 0, 0, 0, 0);
    nxt();
    check("single_gap", cdb_valid, 1'b0);

    // Simple contention after reset.
    do_reset();
    set(1, 1, 'hA, 1, 2, 'hB);
    nxt();
    check("cont_first_tag", cdb_rob_id, 1);
    check("cont_first_src", cdb_src, 1'b0);
    set(0, 0, 0, 0, 0, 0);
    nxt();
    check("cont_second_valid", cdb_valid, 1'b1);
    check("cont_second_tag", cdb_rob_id, 2);
    check("cont_second_result", cdb_result, 'hB);
    check("cont_second_src", cdb_src, 1'b1);

    // Sustained contention: grants alternate ALU, LSB, ...
    do_reset();
    tag_a = 0; tag_l = 0;
    for (int i = 0; i < 8; i++) begin
      bit va, vl;
      va = (mq_a.size() < D);
      vl = (mq_l.size() < D);
      set(va, (tag_a % 15) + 1, 'h100 + tag_a, vl, (tag_l % 15) + 1, 'h200 + tag_l);
      if (va) tag_a++;
      if (vl) tag_l++;
      nxt();
      check("sustain_valid", cdb_valid, 1'b1);
      check("sustain_src", cdb_src, i % 2);
    end
    set(0, 0, 0, 0, 0, 0);
    repeat (6) nxt();
    check("sustain_drained", cdb_valid, 1'b0);

    // Backpressure: LSB fills to DEPTH behind contention.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set(1, i + 1, 'h300 + i, mq_l.size() < D, i + 8, 'h400 + i);
      nxt();
      if (i == 2) check("bp_lsb_full", ready_to_lsb, 1'b0);
      if (i == 2) check("bp_alu_open", ready_to_alu, 1'b1);
      if (i == 3) check("bp_lsb_reopen", ready_to_lsb, 1'b1);
    end
    set(0, 0, 0, 0, 0, 0);
    repeat (5) nxt();

    // Rollback with two LSB entries queued and a new ALU input.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set(1, i + 1, 'h500 + i, mq_l.size() < D, i + 8, 'h600 + i);
      nxt();
    end
    set(1, 5, 'h555, 0, 0, 0, 1);
    nxt();
    check("rb_cdb_valid", cdb_valid, 1'b0);
    check("rb_ready_alu", ready_to_alu, 1'b1);
    check("rb_ready_lsb", ready_to_lsb, 1'b1);
    set(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      check("rb_no_stale", cdb_valid, 1'b0);
    end

    // Freeze with an ALU entry queued behind an LSB broadcast.
    do_reset();
    set(1, 1, 'h71, 1, 2, 'h72);
    nxt();
    set(0, 0, 0, 0, 0, 0);
    nxt();
    set(1, 3, 'h73, 1, 4, 'h74);
    nxt();
    check("frz_pre_tag", cdb_rob_id, 4);
    check("frz_pre_src", cdb_src, 1'b1);
    for (int i = 0; i < 3; i++) begin
      // Rollback during freeze must be ignored.
      set(0, 0, 0, 0, 0, 0, i == 1, 0);
      nxt();
      check("frz_valid_hold", cdb_valid, 1'b1);
      check("frz_tag_hold", cdb_rob_id, 4);
      check("frz_ready_alu", ready_to_alu, 1'b0);
      check("frz_ready_lsb", ready_to_lsb, 1'b0);
    end
    set(0, 0, 0, 0, 0, 0);
    nxt();
    check("frz_post_tag", cdb_rob_id, 3);
    check("frz_post_result", cdb_result, 'h73);
    check("frz_post_src", cdb_src, 1'b0);
    nxt();
    check("frz_post_idle", cdb_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
